// File: rtl/noc_credit_tx_if.sv
// FIFO-side and link-side handshake bundle for noc_credit_tx.
// master = transmitter, slave = FIFO/link environment.
interface noc_credit_tx_if #(
   parameter int WIDTH = 32
);
   logic             i_fifo_empty;
   logic [WIDTH-1:0] i_fifo_data;
   logic             i_fifo_head;
   logic             i_fifo_tail;
   logic             o_fifo_pop;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic             o_head;
   logic             o_tail;
   logic             i_credit;

   modport master (
      input  i_fifo_empty, i_fifo_data, i_fifo_head, i_fifo_tail, i_credit,
      output o_fifo_pop, o_valid, o_data, o_head, o_tail
   );

   modport slave (
      output i_fifo_empty, i_fifo_data, i_fifo_head, i_fifo_tail, i_credit,
      input  o_fifo_pop, o_valid, o_data, o_head, o_tail
   );
endinterface

// File: rtl/noc_credit_tx.sv
// Credit-based NoC link transmitter: pops the output FIFO while downstream credits remain.
// Define NOC_CREDIT_TX_PKT_CHECK_EN to compile in the head/tail framing checker (o_proto_err).
module noc_credit_tx #(
   parameter  int WIDTH   = 32,
   parameter  int CREDITS = 8,
   localparam int CW      = $clog2(CREDITS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clear,
   noc_credit_tx_if.master      link,
   output logic [CW-1:0]        o_credit_count,
   output logic                 o_in_packet,
   output logic                 o_credit_err,
   output logic                 o_proto_err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    credit_q, credit_d;
   logic             cerr_q, cerr_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic             pop_s;

   // Pop decision uses only the registered count; a same-cycle credit cannot enable it.
   always_comb begin
      pop_s = 1'b0;
      if (!i_clear && !link.i_fifo_empty && (credit_q != {CW{1'b0}})) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Credit counter next state and overflow detection.
   always_comb begin
      credit_d = credit_q;
      cerr_d   = cerr_q;
      case ({pop_s, link.i_credit})
         2'b10: credit_d = credit_q - CW'(1);
         2'b01: begin
            if (credit_q == CW'(CREDITS)) begin
               cerr_d = 1'b1;
            end else begin
               credit_d = credit_q + CW'(1);
            end
         end
         default: credit_d = credit_q;
      endcase
   end

   // Framing FSM next state, advanced only on pops.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pop_s && link.i_fifo_head && !link.i_fifo_tail) begin
               state_d = ST_BODY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BODY: begin
            if (pop_s && link.i_fifo_tail) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BODY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Launch register next values; payload and markers hold when nothing is popped.
   always_comb begin
      valid_d = pop_s;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (pop_s) begin
         data_d = link.i_fifo_data;
         head_d = link.i_fifo_head;
         tail_d = link.i_fifo_tail;
      end else begin
         data_d = data_q;
         head_d = head_q;
         tail_d = tail_q;
      end
   end

   // State registers with async reset and synchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         credit_q <= CW'(CREDITS);
         cerr_q   <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= {WIDTH{1'b0}};
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
      end else if (i_clear) begin
         state_q  <= ST_IDLE;
         credit_q <= CW'(CREDITS);
         cerr_q   <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= {WIDTH{1'b0}};
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         cerr_q   <= cerr_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
      end
   end

`ifdef NOC_CREDIT_TX_PKT_CHECK_EN
   logic perr_q, perr_d;

   // Sticky framing error: body without head, or head inside an open packet.
   always_comb begin
      perr_d = perr_q;
      if (pop_s && (((state_q == ST_IDLE) && !link.i_fifo_head) ||
                    ((state_q == ST_BODY) && link.i_fifo_head))) begin
         perr_d = 1'b1;
      end else begin
         perr_d = perr_q;
      end
   end

   // Framing error register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q <= 1'b0;
      end else if (i_clear) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign o_proto_err = perr_q;
`else
   assign o_proto_err = 1'b0;
`endif

   assign link.o_fifo_pop = pop_s;
   assign link.o_valid    = valid_q;
   assign link.o_data     = data_q;
   assign link.o_head     = head_q;
   assign link.o_tail     = tail_q;
   assign o_credit_count  = credit_q;
   assign o_in_packet     = (state_q == ST_BODY);
   assign o_credit_err    = cerr_q;

endmodule
